// File: rtl/regwr_pkg.sv
// Shared definitions for the register-file write arbiter: requester indices,
// default geometry of the 16x8 accumulator register file, and the request record.
package regwr_pkg;

    // Requester indices (fixed priority: lower index wins)
    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_IMM  = 2;

    // Default data width, address width and requester count
    localparam int unsigned DEF_W = 8;
    localparam int unsigned DEF_D = 4;
    localparam int unsigned DEF_N = 3;

    // One write request at the default geometry
    typedef struct packed {
        logic [DEF_D-1:0] addr;
        logic [DEF_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational N-way one-hot picker. Searches the request vector starting at
// i_start and wrapping around; the first set bit wins. Tying i_start to zero
// gives plain fixed priority with index 0 highest.
module rr_picker #(
    parameter int unsigned N = 3,
    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IdW-1:0] i_start,
    output logic [N-1:0]   o_gnt,
    output logic [IdW-1:0] o_gnt_id,
    output logic           o_any
);

    logic [IdW-1:0] w_idx;

    // Rotating first-one search from the start pointer
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = IdW'((32'(i_start) + k) % N);
            if (!o_any && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the single register-file write port among N requesters
// (ALU result, memory load, immediate/move) with a valid/ready handshake.
// The accepted request is registered onto write_en/waddr/data_in one cycle later.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise fixed
// priority with requester 0 highest.
module reg_write_arbiter
    import regwr_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned D = DEF_D,
    parameter int unsigned N = DEF_N,
    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_stall,
    input  logic [N-1:0]   i_req_valid,
    input  logic [N*D-1:0] i_req_addr,
    input  logic [N*W-1:0] i_req_data,
    output logic [N-1:0]   o_req_ready,
    output logic           o_write_en,
    output logic [D-1:0]   o_waddr,
    output logic [W-1:0]   o_data_in,
    output logic [IdW-1:0] o_grant_id,
    output logic [15:0]    o_wr_count
);

    logic [D-1:0]   w_addr_arr [N];
    logic [W-1:0]   w_data_arr [N];
    logic [N-1:0]   w_pick_gnt;
    logic [IdW-1:0] w_pick_id;
    logic           w_pick_any;
    logic           w_arb_en;
    logic           w_hs;

    logic           r_write_en;
    logic [D-1:0]   r_waddr;
    logic [W-1:0]   r_data_in;
    logic [IdW-1:0] r_grant_id;
    logic [15:0]    r_wr_count;

    // Split the flat request buses into per-requester fields
    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_addr_arr[g] = i_req_addr[g*D +: D];
        assign w_data_arr[g] = i_req_data[g*W +: W];
    end

`ifdef ARB_RR_EN
    logic [IdW-1:0] r_rr_ptr;

    rr_picker #(
        .N (N)
    ) u_picker (
        .i_req    (i_req_valid),
        .i_start  (r_rr_ptr),
        .o_gnt    (w_pick_gnt),
        .o_gnt_id (w_pick_id),
        .o_any    (w_pick_any)
    );

    // Round-robin pointer moves just past the winner; holds when idle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_pick_id == IdW'(N - 1)) ? '0 : w_pick_id + 1'b1;
        end
    end
`else
    rr_picker #(
        .N (N)
    ) u_picker (
        .i_req    (i_req_valid),
        .i_start  ('0),
        .o_gnt    (w_pick_gnt),
        .o_gnt_id (w_pick_id),
        .o_any    (w_pick_any)
    );
`endif

    // Ready is masked during reset and stall so no handshake can be lost
    always_comb begin
        w_arb_en    = i_rst_n & ~i_stall;
        o_req_ready = w_arb_en ? w_pick_gnt : '0;
        w_hs        = w_arb_en & w_pick_any;
    end

    // Output write port and committed-write counter; a pending write is dropped on reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_write_en <= 1'b0;
            r_waddr    <= '0;
            r_data_in  <= '0;
            r_grant_id <= '0;
            r_wr_count <= '0;
        end else begin
            r_write_en <= w_hs;
            if (w_hs) begin
                r_waddr    <= w_addr_arr[w_pick_id];
                r_data_in  <= w_data_arr[w_pick_id];
                r_grant_id <= w_pick_id;
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end
        end
    end

    assign o_write_en = r_write_en;
    assign o_waddr    = r_waddr;
    assign o_data_in  = r_data_in;
    assign o_grant_id = r_grant_id;
    assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter. A policy model predicts req_ready
// each cycle and pushes the expected write onto a scoreboard queue; the entry is
// popped and compared when the DUT raises write_en. Follows ARB_RR_EN if defined.
module tb_reg_write_arbiter;
    import regwr_pkg::*;

    localparam int unsigned W   = DEF_W;
    localparam int unsigned D   = DEF_D;
    localparam int unsigned N   = DEF_N;
    localparam int unsigned IdW = 2;

    typedef struct packed {
        wr_req_t        req;
        logic [IdW-1:0] id;
        logic [15:0]    cnt;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           stall;
    logic [N-1:0]   req_valid;
    logic [N*D-1:0] req_addr;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           write_en;
    logic [D-1:0]   waddr;
    logic [W-1:0]   data_in;
    logic [IdW-1:0] grant_id;
    logic [15:0]    wr_count;

    sb_t         sb_q[$];
    int          gnt_log[$];
    int          errors = 0;
    int          checks = 0;
    int          m_ptr  = 0;
    logic [15:0] m_cnt  = '0;
    logic        m_we   = 1'b0;
    bit          auto_drop = 1'b0;
    logic [W-1:0] last_r3 = '0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .W (W),
        .D (D),
        .N (N)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_stall     (stall),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_write_en  (write_en),
        .o_waddr     (waddr),
        .o_data_in   (data_in),
        .o_grant_id  (grant_id),
        .o_wr_count  (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration policy: first valid requester searching upward from start
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int start);
        logic [N-1:0] g;
        bit found;
        g = '0;
        found = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            int idx;
            idx = (start + k) % int'(N);
            if (!found && v[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    // One clock: check ready at negedge, check registered outputs 1 ns after posedge
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        int   id;
        sb_t  e;
        @(negedge clk);
        exp_rdy = (rst_n && !stall) ? model_pick(req_valid, m_ptr) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        m_we = 1'b0;
        id   = 0;
        if (exp_rdy != '0) begin
            for (int i = 0; i < int'(N); i++) if (exp_rdy[i]) id = i;
            e.req.addr = req_addr[id*D +: D];
            e.req.data = req_data[id*W +: W];
            e.id       = IdW'(id);
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            e.cnt = m_cnt;
            sb_q.push_back(e);
            m_we = 1'b1;
`ifdef ARB_RR_EN
            m_ptr = (id + 1) % int'(N);
`endif
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sb_q.delete();
            m_cnt = '0;
            m_ptr = 0;
            m_we  = 1'b0;
        end
        chk("write_en", 32'(write_en), 32'(m_we));
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        if (write_en === 1'b1) begin
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_waddr", 32'(waddr), 32'(e.req.addr));
                chk("sb_data_in", 32'(data_in), 32'(e.req.data));
                chk("sb_grant_id", 32'(grant_id), 32'(e.id));
                chk("sb_wr_count", 32'(wr_count), 32'(e.cnt));
                gnt_log.push_back(int'(grant_id));
                if (waddr === 4'h3) last_r3 = data_in;
            end else begin
                chk("spurious_write_en", 32'(write_en), 32'd0);
            end
        end
        if (auto_drop && m_we) req_valid[id] = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    int exp_seq[6];

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        req_valid = 3'b111;
        req_addr  = {4'hC, 4'hB, 4'hA};
        req_data  = {8'h33, 8'h22, 8'h11};

        // Reset held two cycles with every requester valid
        cycle();
        cycle();
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);

        rst_n     = 1'b1;
        req_valid = 3'b000;
        cycle();

        // Single request from the load port
        auto_drop = 1'b1;
        req_addr[REQ_LOAD*D +: D] = 4'h5;
        req_data[REQ_LOAD*W +: W] = 8'hA7;
        req_valid = 3'b010;
        cycle();
        chk("single_write_en", 32'(write_en), 32'd1);
        chk("single_waddr", 32'(waddr), 32'h5);
        chk("single_data_in", 32'(data_in), 32'hA7);
        chk("single_grant_id", 32'(grant_id), 32'(REQ_LOAD));
        chk("single_wr_count", 32'(wr_count), 32'd1);
        cycle();
        chk("idle_write_en", 32'(write_en), 32'd0);
        chk("idle_hold_waddr", 32'(waddr), 32'h5);
        chk("idle_hold_data", 32'(data_in), 32'hA7);

        // Contention: all three valid for six cycles
        reset_pulse();
        auto_drop = 1'b0;
        gnt_log.delete();
        req_valid = 3'b111;
        repeat (6) cycle();
`ifdef ARB_RR_EN
        exp_seq = '{0, 1, 2, 0, 1, 2};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
        chk("contention_len", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < gnt_log.size()) chk("contention_order", 32'(gnt_log[i]), 32'(exp_seq[i]));
        end
        req_valid = 3'b000;
        cycle();

        // Same destination from ALU and immediate; later grant wins
        reset_pulse();
        auto_drop = 1'b1;
        req_addr[REQ_ALU*D +: D] = 4'h3;
        req_data[REQ_ALU*W +: W] = 8'h11;
        req_addr[REQ_IMM*D +: D] = 4'h3;
        req_data[REQ_IMM*W +: W] = 8'h22;
        req_valid = 3'b101;
        cycle();
        chk("same_addr_we1", 32'(write_en), 32'd1);
        chk("same_addr_first", 32'(last_r3), 32'h11);
        cycle();
        chk("same_addr_we2", 32'(write_en), 32'd1);
        chk("same_addr_gid2", 32'(grant_id), 32'(REQ_IMM));
        chk("same_addr_final", 32'(last_r3), 32'h22);
        cycle();

        // Stall holds off the ALU request for three cycles
        req_addr[REQ_ALU*D +: D] = 4'h7;
        req_data[REQ_ALU*W +: W] = 8'h5C;
        req_valid = 3'b001;
        stall     = 1'b1;
        repeat (3) cycle();
        chk("stall_write_en", 32'(write_en), 32'd0);
        chk("stall_count", 32'(wr_count), 32'd2);
        stall = 1'b0;
        cycle();
        chk("unstall_write_en", 32'(write_en), 32'd1);
        chk("unstall_gid", 32'(grant_id), 32'(REQ_ALU));
        chk("unstall_waddr", 32'(waddr), 32'h7);

        // Saturation: stream writes up to FFFE, then three more
        reset_pulse();
        auto_drop = 1'b0;
        req_valid = 3'b001;
        repeat (65534) cycle();
        chk("sat_fffe", 32'(wr_count), 32'hFFFE);
        repeat (3) cycle();
        chk("sat_ffff", 32'(wr_count), 32'hFFFF);
        chk("sat_write_en", 32'(write_en), 32'd1);

        // Reset the cycle after a handshake discards the pending write
        rst_n = 1'b0;
        cycle();
        chk("midrst_write_en", 32'(write_en), 32'd0);
        chk("midrst_wr_count", 32'(wr_count), 32'd0);
        rst_n     = 1'b1;
        req_valid = 3'b000;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the single write port of the 16×8 accumulator-style register file (register 0 is the implicit A operand) among N requesters: ALU result, memory load and immediate/move. It grants one requester per cycle with a valid/ready handshake. It drives the register file's write_en/waddr/data_in from registered outputs and sits between the execute/memory stages and the register file.

## Interface
- W, 8, data width; matches register file width
- D, 4, address width; 2**D registers
- N, 3, number of requesters; index 0 = ALU, 1 = load, 2 = immediate
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk
- stall  input  1  holds off all grants while high
- req_valid  input  N  per-requester write request
- req_addr  input  N×D  per-requester destination register
- req_data  input  N×W  per-requester write data
- req_ready  output  N  one-hot grant/accept; a handshake occurs on valid&ready at posedge
- write_en  output  1  register-file write enable (registered)
- waddr  output  D  register-file write address (registered)
- data_in  output  W  register-file write data (registered)
- grant_id  output  $clog2(N)  index of the requester that owns the current write_en cycle
- wr_count  output  16  saturating count of committed writes

## Operation
- Reset (rst_n low at posedge): write_en=0, waddr=0, data_in=0, grant_id=0, wr_count=0, rr_ptr=0. req_ready is forced to all-zero combinationally while rst_n is low, so no handshake is lost across reset.
- Arbitration is combinational each cycle: candidates are requesters with req_valid=1. If stall=1 or rst_n=0, req_ready=0. Otherwise exactly one candidate gets req_ready=1, chosen by the arbitration policy (see Configuration).
- req_ready never asserts for a requester whose req_valid=0. Requesters hold valid, addr and data stable until they are accepted.
- On a handshake from requester i: the next cycle has write_en=1, waddr=req_addr[i], data_in=req_data[i], grant_id=i, and wr_count increments, saturating at 16'hFFFF.
- With no handshake, write_en=0 in the next cycle. waddr, data_in and grant_id hold their last values.
- Same-address requests from two requesters are committed in grant order. The later grant's data is the final register value.
- Writes to register 0 (the accumulator) receive no special handling.
- An ungranted requester keeps waiting. Under round-robin, every continuously valid requester is granted within N cycles of non-stalled operation.

## Timing
- Latency: handshake at edge e, write_en high for the cycle after e, register file updated at edge e+1. Total: 2 edges from accept to visible register contents.
- Throughput: one write per cycle. The output register always drains because the register file never back-pressures.
- stall: takes effect in the same cycle (combinational on req_ready). A write already registered still completes in the stalled cycle.
- Reset mid-operation: a pending registered write is discarded (write_en=0 after reset). Requesters re-present after rst_n deasserts.

## Configuration
- ARB_RR_EN defined: round-robin policy. Priority search starts at rr_ptr. On a grant to i, rr_ptr ← (i+1) mod N. rr_ptr holds when there is no grant.
- ARB_RR_EN undefined: fixed priority, with index 0 highest. rr_ptr is not implemented.

## Structure
- Shared package regwr_pkg: REQ_ALU=0, REQ_LOAD=1, REQ_IMM=2 constants; the default W/D/N values; and typedef wr_req_t {addr, data}.
- One sub-module, rr_picker: combinational N-way one-hot picker with a start-pointer input. It is instantiated with start=0 when ARB_RR_EN is undefined.
- The top holds the output registers, rr_ptr and wr_count.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, write_en=0, wr_count=0 throughout.
- Single request: req_valid=3'b010, addr=4'h5, data=8'hA7 -> req_ready[1]=1 the same cycle. Next cycle: write_en=1, waddr=5, data_in=A7, grant_id=1, wr_count=1.
- Contention: all three requesters valid for 6 cycles with ARB_RR_EN defined -> grants 0,1,2,0,1,2. With ARB_RR_EN undefined -> six grants to 0.
- Same address: req 0 writes reg 3 = 8'h11 and req 2 writes reg 3 = 8'h22, both valid -> two consecutive write_en cycles. Register 3 ends at the second-granted value.
- Stall: stall=1 for 3 cycles with req_valid=3'b001 -> req_ready=0 and no new write_en. On stall falling, req 0 is granted the same cycle.
- Saturation/reset mid-stream: preload wr_count to FFFE and issue 3 writes -> wr_count stays at FFFF. Asserting rst_n=0 the cycle after a handshake -> write_en=0 and wr_count=0.
